// File: rtl/ov7670_capture_320.sv
`default_nettype none
// ============================================================================
//  Module      : ov7670_capture_320
//  Description : OV7670 RGB565 capture with 2:1 decimation in x and y
//                (640x480 -> 320x240) into a linear frame buffer.
//                Inputs are registered once; all logic runs on the
//                registered copies, with edges found against a second delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module ov7670_capture_320 #(
    parameter int H_IN     = 640,
    parameter int V_IN     = 480,
    parameter int FB_DEPTH = 76800
) (
    input  logic        PCLK,
    input  logic        Nreset,
    input  logic        enable,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  d,
    output logic        we,
    output logic [16:0] addr,
    output logic [15:0] dout,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    localparam logic [10:0] c_H_LIMIT  = 11'(H_IN);
    localparam logic [16:0] c_FB_LIMIT = 17'(FB_DEPTH);
    localparam logic [10:0] c_COL_MAX  = 11'h7FF;
    localparam logic [9:0]  c_ROW_MAX  = 10'h3FF;

    // V_IN documents the nominal frame height; rows past it are bounded by
    // the frame-buffer depth limit, which also raises the overrun flag.
    localparam int c_V_NOMINAL = V_IN;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_vs_q, r_vs_qq;
    logic        r_hr_q, r_hr_qq;
    logic [7:0]  r_d_q;

    logic        w_vs_rise, w_vs_fall, w_hr_rise, w_hr_fall;
    logic        w_enter_active, w_frame_end, w_in_active;

    logic        r_phase;
    logic [7:0]  r_high;
    logic [10:0] r_col;
    logic [9:0]  r_row;
    logic [15:0] r_pix;
    logic        r_pix_valid;
    logic        r_pix_keep;

    logic [16:0] r_addr_cnt;
    logic        r_we;
    logic [16:0] r_addr;
    logic [15:0] r_dout;
    logic        r_frame_done;
    logic        r_overrun;

    assign w_vs_rise   =  r_vs_q & ~r_vs_qq;
    assign w_vs_fall   = ~r_vs_q &  r_vs_qq;
    assign w_hr_rise   =  r_hr_q & ~r_hr_qq;
    assign w_hr_fall   = ~r_hr_q &  r_hr_qq;
    assign w_in_active = (r_state == ST_ACTIVE);

    // Single input register stage plus a delayed copy for edge detection
    always_ff @(posedge PCLK or negedge Nreset) begin
        if (!Nreset) begin
            r_vs_q  <= 1'b0;
            r_vs_qq <= 1'b0;
            r_hr_q  <= 1'b0;
            r_hr_qq <= 1'b0;
            r_d_q   <= 8'h00;
        end else begin
            r_vs_q  <= vsync;
            r_vs_qq <= r_vs_q;
            r_hr_q  <= href;
            r_hr_qq <= r_hr_q;
            r_d_q   <= d;
        end
    end

    // Frame state register
    always_ff @(posedge PCLK or negedge Nreset) begin
        if (!Nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Frame state transitions; enable only matters on a vsync rising edge
    always_comb begin
        w_state_next   = r_state;
        w_enter_active = 1'b0;
        w_frame_end    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_vs_rise && enable) begin
                    w_state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (w_vs_fall) begin
                    w_state_next   = ST_ACTIVE;
                    w_enter_active = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_vs_rise) begin
                    w_frame_end  = 1'b1;
                    w_state_next = enable ? ST_SYNC : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Byte pairing, column/row tracking and keep decision for each pixel
    always_ff @(posedge PCLK or negedge Nreset) begin
        if (!Nreset) begin
            r_phase     <= 1'b0;
            r_high      <= 8'h00;
            r_col       <= 11'd0;
            r_row       <= 10'd0;
            r_pix       <= 16'h0000;
            r_pix_valid <= 1'b0;
            r_pix_keep  <= 1'b0;
        end else if (w_enter_active) begin
            r_phase     <= 1'b0;
            r_high      <= 8'h00;
            r_col       <= 11'd0;
            r_row       <= 10'd0;
            r_pix_valid <= 1'b0;
            r_pix_keep  <= 1'b0;
        end else if (w_in_active) begin
            r_pix_valid <= 1'b0;
            if (r_hr_q) begin
                if (w_hr_rise) begin
                    // First byte of a line is always a high byte, even if
                    // the previous line ended half-way through a pixel.
                    r_high  <= r_d_q;
                    r_phase <= 1'b1;
                    r_col   <= 11'd0;
                end else if (!r_phase) begin
                    r_high  <= r_d_q;
                    r_phase <= 1'b1;
                end else begin
                    r_phase     <= 1'b0;
                    r_pix       <= {r_high, r_d_q};
                    r_pix_valid <= 1'b1;
                    r_pix_keep  <= ~r_col[0] & ~r_row[0] & (r_col < c_H_LIMIT);
                    if (r_col != c_COL_MAX) begin
                        r_col <= r_col + 11'd1;
                    end
                end
            end
            if (w_hr_fall && (r_row != c_ROW_MAX)) begin
                r_row <= r_row + 10'd1;
            end
        end else begin
            r_pix_valid <= 1'b0;
        end
    end

    // Frame-buffer write strobe, address counter and overrun flag
    always_ff @(posedge PCLK or negedge Nreset) begin
        if (!Nreset) begin
            r_we         <= 1'b0;
            r_addr       <= 17'd0;
            r_dout       <= 16'h0000;
            r_addr_cnt   <= 17'd0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_we         <= 1'b0;
            r_frame_done <= w_frame_end;
            if (w_enter_active) begin
                r_addr_cnt <= 17'd0;
                r_overrun  <= 1'b0;
            end else if (w_in_active && !w_vs_rise && r_pix_valid && r_pix_keep) begin
                if (r_addr_cnt < c_FB_LIMIT) begin
                    r_we       <= 1'b1;
                    r_addr     <= r_addr_cnt;
                    r_dout     <= r_pix;
                    r_addr_cnt <= r_addr_cnt + 17'd1;
                end else begin
                    r_overrun  <= 1'b1;
                end
            end
        end
    end

    assign we         = r_we;
    assign addr       = r_addr;
    assign dout       = r_dout;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_capture_320.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ov7670_capture_320
//  Description : Self-checking bench for ov7670_capture_320 using a reduced
//                16x8 geometry (32-word buffer), a scenario table and a
//                write scoreboard fed by a reference model of the decimation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ov7670_capture_320;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int FB = 32;

    logic        PCLK = 1'b0;
    logic        Nreset, enable, vsync, href;
    logic [7:0]  d;
    logic        we, busy, frame_done, overrun;
    logic [16:0] addr;
    logic [15:0] dout;

    ov7670_capture_320 #(.H_IN(H), .V_IN(V), .FB_DEPTH(FB)) dut (
        .PCLK(PCLK), .Nreset(Nreset), .enable(enable), .vsync(vsync),
        .href(href), .d(d), .we(we), .addr(addr), .dout(dout),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int lines;
        int nbytes;
        int kind;       // 0 ramp, 1 odd rows/cols = FF, 2 ramp with F8/1F lead
        bit active;     // frame expected to be captured
        bit en_after;   // enable value applied after the first line
        int exp_writes;
        bit exp_ovr;
        int exp_fd;
        bit exp_busy;
    } scen_t;

    typedef struct packed {
        logic [16:0] a;
        logic [15:0] p;
    } wr_t;

    wr_t   sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    int    n_writes = 0;
    int    n_fd     = 0;
    int    m_cnt    = 0;
    int    t_1f     = 0;
    int    t_we     = 0;
    bit    lat_armed = 1'b0;
    bit    lat_seen  = 1'b0;
    bit    ffff_seen = 1'b0;
    scen_t scen[8];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic logic [7:0] byte_of(input int kind, input int r, input int b);
        logic [7:0] v;
        v = 8'(r * 3 + b);
        if (kind == 1) v = (((r % 2) == 1) || (((b / 2) % 2) == 1)) ? 8'hFF : 8'h00;
        if (kind == 2 && r == 0 && b == 0) v = 8'hF8;
        if (kind == 2 && r == 0 && b == 1) v = 8'h1F;
        return v;
    endfunction

    // Cycle counter (posedges seen so far)
    initial forever begin
        @(posedge PCLK);
        cyc++;
    end

    // Output monitor: pops the scoreboard on every write strobe
    initial forever begin
        wr_t e;
        @(negedge PCLK);
        if (Nreset) begin
            if (we) begin
                n_writes++;
                if (dout == 16'hFFFF) ffff_seen = 1'b1;
                if (lat_armed && !lat_seen) begin
                    t_we     = cyc;
                    lat_seen = 1'b1;
                end
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: addr %0d dout %04h, no write expected", addr, dout);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", addr, e.a);
                    chk("wr_dout", dout, e.p);
                end
            end
            if (frame_done) n_fd++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // One camera line; the model pushes the writes this line should cause
    task automatic drive_line(input int r, input int nb, input int kind, input bit active);
        wr_t w;
        if (active) begin
            for (int c = 0; 2 * c + 1 < nb; c++) begin
                if ((c % 2) == 0 && (r % 2) == 0 && c < H && m_cnt < FB) begin
                    w.a = 17'(m_cnt);
                    w.p = {byte_of(kind, r, 2 * c), byte_of(kind, r, 2 * c + 1)};
                    sb.push_back(w);
                    m_cnt++;
                end
            end
        end
        for (int b = 0; b < nb; b++) begin
            @(negedge PCLK);
            href = 1'b1;
            d    = byte_of(kind, r, b);
            if (kind == 2 && r == 0 && b == 1) begin
                t_1f      = cyc;
                lat_armed = 1'b1;
            end
        end
        @(negedge PCLK);
        href = 1'b0;
        d    = 8'h00;
        repeat (3) @(negedge PCLK);
    endtask

    task automatic run_frame(input scen_t s, input string tag);
        if (!vsync) begin
            @(negedge PCLK);
            vsync = 1'b1;
        end
        repeat (3) @(negedge PCLK);
        vsync = 1'b0;
        if (s.active) m_cnt = 0;
        repeat (4) @(negedge PCLK);
        n_writes = 0;
        n_fd     = 0;
        chk({tag, "_ovr_after_entry"}, overrun, 0);
        for (int r = 0; r < s.lines; r++) begin
            drive_line(r, s.nbytes, s.kind, s.active);
            if (r == 0) enable = s.en_after;
        end
        @(negedge PCLK);
        vsync = 1'b1;
        repeat (5) @(negedge PCLK);
        chk({tag, "_writes"},     n_writes,  s.exp_writes);
        chk({tag, "_overrun"},    overrun,   s.exp_ovr);
        chk({tag, "_frame_done"}, n_fd,      s.exp_fd);
        chk({tag, "_busy"},       busy,      s.exp_busy);
        chk({tag, "_sb_empty"},   sb.size(), 0);
    endtask

    initial begin
        Nreset = 1'b1;
        enable = 1'b1;
        vsync  = 1'b0;
        href   = 1'b0;
        d      = 8'h00;

        //              lines nbytes kind act en  wr  ovr fd busy
        scen[0] = '{V,     2*H,   0, 1, 1, FB, 0, 1, 1};  // plain ramp frame
        scen[1] = '{V,     2*H,   1, 1, 1, FB, 0, 1, 1};  // odd rows/cols are FFFF
        scen[2] = '{V,     2*H,   2, 1, 1, FB, 0, 1, 1};  // F8,1F lead pixel
        scen[3] = '{V + 2, 2*H,   0, 1, 1, FB, 1, 1, 1};  // two extra lines
        scen[4] = '{V,     2*H+1, 0, 1, 1, FB, 0, 1, 1};  // odd byte count lines
        scen[5] = '{V,     2*H,   0, 1, 0, FB, 0, 1, 0};  // enable drops mid-frame
        scen[6] = '{V,     2*H,   0, 0, 1, 0,  0, 0, 1};  // idle frame, enable back
        scen[7] = '{V,     2*H,   0, 1, 1, FB, 0, 1, 1};  // capture resumes

        #2 Nreset = 1'b0;
        #1 chk("reset_outputs", {we, addr, dout, busy, frame_done, overrun}, 0);
        repeat (3) @(negedge PCLK);
        Nreset = 1'b1;
        repeat (2) @(negedge PCLK);

        for (int i = 0; i < 8; i++) begin
            run_frame(scen[i], $sformatf("scen%0d", i));
            if (i == 1) chk("no_ffff_written", ffff_seen, 0);
            if (i == 2) begin
                chk("latency_seen", lat_seen, 1);
                chk("latency_cycles", t_we - t_1f, 3);
            end
        end

        // Reset in the middle of an odd (non-kept) line
        @(negedge PCLK);
        vsync = 1'b0;
        m_cnt = 0;
        repeat (4) @(negedge PCLK);
        drive_line(0, 2 * H, 0, 1'b1);
        for (int b = 0; b < 10; b++) begin
            @(negedge PCLK);
            href = 1'b1;
            d    = byte_of(0, 1, b);
        end
        chk("pre_reset_addr", addr, H / 2 - 1);
        #2 Nreset = 1'b0;
        #1 chk("midline_reset_outputs", {we, addr, dout, busy, frame_done, overrun}, 0);
        sb.delete();
        @(negedge PCLK);
        Nreset   = 1'b1;
        n_writes = 0;
        for (int b = 10; b < 2 * H; b++) begin
            @(negedge PCLK);
            d = byte_of(0, 1, b);
        end
        @(negedge PCLK);
        href = 1'b0;
        repeat (3) @(negedge PCLK);
        for (int r = 2; r < V; r++) drive_line(r, 2 * H, 0, 1'b0);
        chk("post_reset_no_writes", n_writes, 0);
        chk("post_reset_busy", busy, 0);
        run_frame(scen[0], "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ov7670_capture_320.md
OV7670_CAPTURE_320 -- requirements
Module: ov7670_capture_320

Interface
REQ-001 SHALL have parameters: H_IN 640 (camera pixels per line); V_IN 480 (camera lines per frame); FB_DEPTH 76800 (frame-buffer words, (H_IN/2)*(V_IN/2)).
REQ-002 SHALL have ports:
- PCLK  input  1  camera pixel clock; sole clock.
- Nreset  input  1  asynchronous, active-low reset.
- enable  input  1  capture permitted; sampled only at frame boundaries.
- vsync  input  1  camera VSYNC, high between frames.
- href  input  1  camera HREF, high during valid line bytes.
- d  input  8  camera data byte, RGB565 high byte first.
- we  output  1  frame-buffer write strobe, one PCLK wide.
- addr  output  17  frame-buffer write address, 0..FB_DEPTH-1.
- dout  output  16  RGB565 pixel for addr.
- busy  output  1  high in SYNC or ACTIVE.
- frame_done  output  1  one-cycle pulse at end of a captured frame.
- overrun  output  1  sticky: frame carried more than FB_DEPTH kept pixels.

Function
REQ-003 SHALL register vsync, href and d once (vs_q, hr_q, d_q); all logic SHALL use the registered copies only, with edges detected against a second delayed copy.
REQ-004 SHALL implement FSM IDLE, SYNC, ACTIVE.
- IDLE -> SYNC on vs_q rising edge with enable=1.
- SYNC -> ACTIVE on vs_q falling edge.
- ACTIVE -> SYNC on vs_q rising edge with enable=1; ACTIVE -> IDLE on vs_q rising edge with enable=0.
REQ-005 SHALL, on entry to ACTIVE, clear the column counter, row counter, byte phase and address counter, and clear overrun.
REQ-006 SHALL, in ACTIVE with hr_q=1, toggle byte phase every PCLK: phase 0 latches d_q as the high byte; phase 1 completes pixel {high, d_q} and increments the column counter.
REQ-007 SHALL reset byte phase and the column counter on every hr_q rising edge.
REQ-008 SHALL discard an incomplete pixel (line ends in phase 1).
REQ-009 SHALL increment the row counter on every hr_q falling edge in ACTIVE.
REQ-010 SHALL keep a completed pixel only when column[0]=0 and row[0]=0 (2:1 decimation in x and y, 640x480 -> 320x240).
REQ-011 SHALL, for each kept pixel with address counter < FB_DEPTH, assert we for exactly one cycle, the cycle after the phase-1 byte is registered.
- During that cycle, addr SHALL equal the address counter and dout the completed pixel.
- The address counter SHALL increment after the write.
REQ-012 SHALL drive addr=row/2*320+col/2 implicitly via sequential increment, with no additive offset; first pixel of a frame written at addr 0.
REQ-013 SHALL suppress we for a kept pixel once the address counter has reached FB_DEPTH, and set overrun; the address SHALL never wrap within a frame.
REQ-014 SHALL pulse frame_done for one cycle on the vs_q rising edge that ends ACTIVE, regardless of enable.
REQ-015 SHALL ignore columns beyond H_IN and rows beyond V_IN for keeping (no write), without error.
REQ-016 SHALL hold addr and dout stable between writes; we SHALL be 0 outside ACTIVE.
REQ-017 SHALL treat enable deassertion mid-frame as taking effect only at the next vs_q rising edge; the current frame completes.

Reset
REQ-018 SHALL, on Nreset=0, immediately force state IDLE, we=0, addr=0, dout=0, busy=0, frame_done=0, overrun=0, and all counters, byte phase and synchroniser registers to 0.
REQ-019 SHALL, after Nreset release mid-frame, not write until a full vsync high-then-low sequence has been observed with enable=1.

Verification
REQ-020 Bench SHALL cover:
- Full frame, enable=1, 640x480 ramp data: exactly 76800 we pulses, addr 0..76799 strictly increasing; first dout = line0 bytes0/1; frame_done once; overrun=0.
- Pixel bytes 0xF8,0x1F at col0,row0: we with addr=0, dout=0xF81F, 3 PCLKs after the 0x1F byte reaches d (reg, compute, strobe).
- Odd rows and odd columns carry 0xFFFF, even ones 0x0000: no written dout equals 0xFFFF.
- 482-line frame: writes stop at addr 76799; extra lines give no we; overrun=1 until next ACTIVE entry.
- Line with odd byte count (1281 bytes): 640 completed pixels, trailing byte discarded, next line starts at phase 0.
- Nreset pulsed low mid-line: outputs zero same cycle; no we until the next vsync fall; next frame starts at addr 0.
